// File: rtl/display_page_if.sv
// Bundle between the page scheduler, its requesters and the display driver.
// The master side owns requests, words and hold; the slave (scheduler) owns the page outputs.
interface display_page_if #(
    parameter int NUM_SRC = 4
);
    localparam int SRC_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]    src_req;
    logic [32*NUM_SRC-1:0] src_data;
    logic                  hold;
    logic [NUM_SRC-1:0]    src_ack;
    logic                  disp_en;
    logic [31:0]           disp_data;
    logic [SRC_W-1:0]      cur_src;
    logic                  page_tick;

    modport master (
        output src_req, src_data, hold,
        input  src_ack, disp_en, disp_data, cur_src, page_tick
    );

    modport slave (
        input  src_req, src_data, hold,
        output src_ack, disp_en, disp_data, cur_src, page_tick
    );
endinterface

// File: rtl/display_page_scheduler.sv
// Round-robin time-sharing of the seven-segment display: each granted source's
// word is snapshotted and shown for DWELL_CYCLES clocks before the grant rotates.
module display_page_scheduler #(
    parameter int NUM_SRC      = 4,
    parameter int DWELL_CYCLES = 100_000_000
) (
    input  logic           clk,
    input  logic           rst,
    display_page_if.slave  bus
);
    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic {
        IDLE,
        SHOW
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    counter;
    logic [SRC_W-1:0]    rr_ptr;
    logic [NUM_SRC-1:0]  src_ack_q;
    logic                disp_en_q;
    logic [31:0]         disp_data_q;
    logic [SRC_W-1:0]    cur_src_q;
    logic                page_tick_q;

    logic                grant_any;
    logic [SRC_W-1:0]    grant_idx;
    logic [SRC_W-1:0]    cand;
    logic [SRC_W-1:0]    next_ptr;
    logic [31:0]         grant_word;
    logic                expiry;
    logic                take_grant;

    // Search upward from the round-robin pointer, wrapping; the first requester wins.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand = SRC_W'((int'(rr_ptr) + i) % NUM_SRC);
            if (!grant_any && bus.src_req[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign next_ptr   = (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
    assign grant_word = bus.src_data[32*grant_idx +: 32];

    // A held page never expires; expiry is re-evaluated on the first unheld cycle.
    assign expiry     = (state == SHOW) && !bus.hold && (counter == CNT_LAST);
    assign take_grant = grant_any && ((state == IDLE) || expiry);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            counter     <= '0;
            rr_ptr      <= '0;
            src_ack_q   <= '0;
            disp_en_q   <= 1'b0;
            disp_data_q <= '0;
            cur_src_q   <= '0;
            page_tick_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            src_ack_q   <= '0;
            page_tick_q <= 1'b0;
            if (take_grant) begin
                state       <= SHOW;
                counter     <= '0;
                rr_ptr      <= next_ptr;
                src_ack_q   <= NUM_SRC'(1) << grant_idx;
                disp_en_q   <= 1'b1;
                disp_data_q <= grant_word;
                cur_src_q   <= grant_idx;
                page_tick_q <= 1'b1;
            end else if (state == SHOW) begin
                if (expiry) begin
                    // Nobody waiting: blank the display but remember who was last shown.
                    state       <= IDLE;
                    disp_en_q   <= 1'b0;
                    disp_data_q <= '0;
                end else if (!bus.hold) begin
                    counter <= counter + 1'b1;
                end
            end
        end
    end

    assign bus.src_ack   = src_ack_q;
    assign bus.disp_en   = disp_en_q;
    assign bus.disp_data = disp_data_q;
    assign bus.cur_src   = cur_src_q;
    assign bus.page_tick = page_tick_q;

endmodule

// File: tb/tb_display_page_scheduler.sv
// Scoreboard bench for display_page_scheduler (NUM_SRC=4, DWELL_CYCLES=4):
// stimulus queues expected grants, a negedge monitor pops and compares on page_tick.
module tb_display_page_scheduler;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int          cyc;
        int          src;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] w[4];

    display_page_if #(.NUM_SRC(4)) bus ();

    display_page_scheduler #(.NUM_SRC(4), .DWELL_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_words();
        bus.src_data = {w[3], w[2], w[1], w[0]};
    endtask

    task automatic push(input int at, input int src, input logic [31:0] data);
        exp_t e;
        e.cyc  = at;
        e.src  = src;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic check_idle(input string name);
        check({name, "_en"}, 32'(bus.disp_en), 32'd0);
        check({name, "_data"}, bus.disp_data, 32'd0);
    endtask

    // Monitor: every page_tick must match the head of the scoreboard in time and content.
    always @(negedge clk) begin
        exp_t e;
        if (bus.page_tick) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_tick at cycle %0d: src %0d ack %b", cyc, bus.cur_src, bus.src_ack);
            end else begin
                e = sb.pop_front();
                check("grant_cycle", 32'(cyc), 32'(e.cyc));
                check("grant_src", 32'(bus.cur_src), 32'(e.src));
                check("grant_data", bus.disp_data, e.data);
                check("grant_ack", 32'(bus.src_ack), 32'(4'(1) << e.src));
                check("grant_en", 32'(bus.disp_en), 32'd1);
            end
        end else begin
            if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_grant at cycle %0d: no tick, expected src %0d at cycle %0d", cyc, e.src, e.cyc);
            end
            check("ack_without_tick", 32'(bus.src_ack), 32'd0);
        end
    end

    initial begin
        // Reset with arbitrary requests pending.
        rst          = 1'b1;
        bus.hold     = 1'b0;
        bus.src_req  = 4'b1111;
        w[0] = 32'h0000_0000; w[1] = 32'h1111_1111; w[2] = 32'h2222_2222; w[3] = 32'h3333_3333;
        apply_words();
        tick(2);
        check("rst_en", 32'(bus.disp_en), 32'd0);
        check("rst_data", bus.disp_data, 32'd0);
        check("rst_ack", 32'(bus.src_ack), 32'd0);
        check("rst_cur_src", 32'(bus.cur_src), 32'd0);
        check("rst_tick", 32'(bus.page_tick), 32'd0);
        rst         = 1'b0;
        bus.src_req = 4'b0000;
        tick(2);
        check_idle("idle_no_req");

        // Sole requester 2 is re-granted every 4 cycles.
        w[2] = 32'hDEAD_BEEF;
        apply_words();
        bus.src_req = 4'b0100;
        for (int k = 0; k < 4; k++) push(cyc + 1 + 4 * k, 2, 32'hDEAD_BEEF);
        tick(3);
        check("mid_page_en", 32'(bus.disp_en), 32'd1);
        tick(10);
        // Drop requests and change the word mid-page: the snapshot stays and the page completes.
        bus.src_req = 4'b0000;
        w[2] = 32'h1234_5678;
        apply_words();
        tick(2);
        check("snapshot_data", bus.disp_data, 32'hDEAD_BEEF);
        tick(2);
        check_idle("after_drop");
        check("after_drop_cur_src", 32'(bus.cur_src), 32'd2);

        // Three requesters rotate from a freshly reset pointer.
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        w[0] = 32'hA0A0_0000; w[1] = 32'hB1B1_0001; w[3] = 32'hC3C3_0003;
        apply_words();
        bus.src_req = 4'b1011;
        push(cyc + 1, 0, w[0]);
        push(cyc + 5, 1, w[1]);
        push(cyc + 9, 3, w[3]);
        push(cyc + 13, 0, w[0]);
        tick(13);
        bus.src_req = 4'b0000;
        tick(4);
        check_idle("rr_end");

        // Hold at count 1 for 10 cycles; next grant lands 3 cycles after release.
        bus.src_req = 4'b0010;
        push(cyc + 1, 1, w[1]);
        tick(2);
        bus.hold = 1'b1;
        tick(10);
        check("hold_en", 32'(bus.disp_en), 32'd1);
        bus.hold = 1'b0;
        push(cyc + 3, 1, w[1]);
        tick(3);
        bus.src_req = 4'b0000;
        tick(4);
        check_idle("hold_end");

        // Reset mid-page while showing source 3; the next grant searches from 0.
        bus.src_req = 4'b1001;
        push(cyc + 1, 3, w[3]);
        tick(2);
        rst = 1'b1;
        tick(1);
        check("midrst_en", 32'(bus.disp_en), 32'd0);
        check("midrst_data", bus.disp_data, 32'd0);
        check("midrst_cur_src", 32'(bus.cur_src), 32'd0);
        check("midrst_ack", 32'(bus.src_ack), 32'd0);
        rst = 1'b0;
        push(cyc + 1, 0, w[0]);
        push(cyc + 5, 3, w[3]);
        tick(5);
        bus.src_req = 4'b0000;
        tick(5);
        check_idle("final");
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
